// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial shift-register link blocks.
package shiftreg_pkg;

    localparam int unsigned SHIFTREG_DEFAULT_WIDTH = 4;
    localparam int unsigned SHIFTREG_MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Even parity of a word; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [SHIFTREG_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shiftreg_bitcnt.sv
// Loadable up-counter spanning 0..WIDTH with a terminal-count flag at WIDTH-1.
// The counter itself wraps; callers gate 'en' to keep it within range.
module shiftreg_bitcnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [$clog2(WIDTH+1)-1:0]   load_val,
    input  logic                         en,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         tc_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Count register: load wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal count marks the final bit position of a word.
    always_comb begin
        tc_c = (cnt == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/shiftreg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake.
// Optional trailing even-parity bit when SHIFTREG_PISO_PARITY_EN is defined.
module shiftreg_piso_tx
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH     = SHIFTREG_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   sreg_q;
    logic [CNT_W-1:0]   cnt;
    logic               tc_c;
    logic               accept_c;
    logic               head_c;
    logic               cnt_en_c;

    assign accept_c = load_valid && load_ready;
    assign head_c   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    // Advance only while shifting, and never past WIDTH.
    assign cnt_en_c = (state_q == SHIFT) && (cnt != CNT_W'(WIDTH));

    shiftreg_bitcnt #(
        .WIDTH    (WIDTH)
    ) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_c),
        .load_val (CNT_W'(0)),
        .en       (cnt_en_c),
        .cnt      (cnt),
        .tc_c     (tc_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register: capture on accept, otherwise move bits toward the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (accept_c) begin
            sreg_q <= din;
        end else if (state_q == SHIFT) begin
            sreg_q <= MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

`ifdef SHIFTREG_PISO_PARITY_EN
    logic par_q;

    // Parity of the captured word, held for the trailing parity cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (accept_c) begin
            par_q <= even_parity(SHIFTREG_MAX_WIDTH'(din));
        end
    end
`endif

    // Next-state and output decode from registered state only.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sout       = head_c;
                sout_valid = 1'b1;
                if (tc_c) begin
`ifdef SHIFTREG_PISO_PARITY_EN
                    state_d = PARITY;
`else
                    last       = 1'b1;
                    load_ready = 1'b1;
                    state_d    = load_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SHIFTREG_PISO_PARITY_EN
            PARITY: begin
                sout       = par_q;
                sout_valid = 1'b1;
                last       = 1'b1;
                load_ready = 1'b1;
                state_d    = load_valid ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/shiftreg_piso_tx.md
# shiftreg_piso_tx

Parallel-in serial-out transmitter: the sending end of our serial shift-register link. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock, LSB first by default, with a qualifying strobe. It sits upstream of `shiftreg_siso`-style serial receivers, driving their `d` input. It supports back-to-back words with no idle bubble.

## Interface
- `WIDTH`, 4: data word width; legal range 2..32.
- `MSB_FIRST`, 0: 0 = bit 0 transmitted first; 1 = bit WIDTH-1 transmitted first.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: parallel word; sampled only on an accepted load.
- `load_valid` in 1: `din` is valid.
- `load_ready` out 1: the block can accept a word this cycle.
- `sout` out 1: serial data bit.
- `sout_valid` out 1: `sout` carries a frame bit this cycle.
- `last` out 1: the current `sout` bit is the final bit of the frame.
- `busy` out 1: a frame is in progress.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the macro described under Configuration.
- Load accept: the load is accepted on a rising edge where `load_valid && load_ready`. On accept:
  - `din` is captured into the shift register.
  - The bit counter is set to 0.
  - The state goes to SHIFT.
- SHIFT:
  - `sout` = current head bit (bit 0, or bit WIDTH-1 when MSB_FIRST=1).
  - `sout_valid` = 1.
  - Each cycle the register shifts toward the head, filling with 0, and the counter increments.
- Last data bit: the counter reaches WIDTH-1.
  - Without parity: `last` = 1 and the next state is IDLE, unless a new load is accepted that same cycle; then the next state is SHIFT with the new word.
  - With parity: the next state is PARITY.
- `load_ready` = (state==IDLE) or (state==SHIFT, counter==WIDTH-1, parity disabled) or (state==PARITY).
- `busy` = (state != IDLE).
- IDLE outputs: `sout`=0, `sout_valid`=0, `last`=0.
- `load_valid` while `load_ready`=0 is ignored; `din` is not sampled. The upstream holds the word until ready.
- Reset values: `load_ready`=1, `sout`=0, `sout_valid`=0, `last`=0, `busy`=0, state IDLE, shift register 0, counter 0.
- Reset mid-frame: the in-flight word is discarded with no partial-frame completion. Reset values apply from the cycle after the reset edge. A `load_valid` in a reset cycle is ignored.
- The counter is $clog2(WIDTH+1) bits wide and never wraps past WIDTH.

## Timing
- Latency: the first bit appears on `sout` the cycle after the accepting edge.
- A frame occupies exactly WIDTH cycles (WIDTH+1 with parity).
- Back-to-back: with a new word accepted in the final-bit cycle, the next frame's first bit follows with zero gap. `sout_valid` stays 1 continuously.
- Outputs are registered or decoded from registered state only, with no combinational path from `din`. `load_ready` does not depend on `load_valid`.

## Configuration
- `SHIFTREG_PISO_PARITY_EN` defined:
  - After the WIDTH data bits, one PARITY cycle emits the even-parity bit, the XOR of the captured word.
  - `sout_valid`=1 and `last`=1 in that cycle; `last` is 0 on the final data bit.
  - Parity is computed at load time and stored in a 1-bit register.
- Macro undefined: no PARITY state and no parity register; frames are WIDTH bits.
- The port list is identical in both builds.

## Structure
- Shared package `shiftreg_pkg`:
  - State enum (IDLE, SHIFT, PARITY).
  - Default width constant `SHIFTREG_DEFAULT_WIDTH = 4`.
  - Parity helper function.
- One natural sub-module, `shiftreg_bitcnt`: loadable up-counter with a terminal-count output, parameterised on WIDTH. It is reused by future serial receivers.

## Test plan
- WIDTH=4, MSB_FIRST=0, load `din`=4'b1011:
  - Next 4 cycles `sout` = 1,1,0,1 with `sout_valid`=1.
  - `last` on the 4th cycle, then IDLE with `load_ready`=1.
- MSB_FIRST=1, `din`=4'b1101 -> `sout` = 1,1,0,1. `din`=4'b0010 -> 0,0,1,0.
- Back-to-back: hold `load_valid` with 4'b1111 then 4'b0000 -> 8 contiguous valid cycles 1,1,1,1,0,0,0,0 with no gap. The second accept occurs in the `last` cycle.
- Reset mid-frame: assert `rst` during bit 2 of 4'b1011:
  - The next cycle shows all reset values and `busy`=0.
  - A following load of 4'b0110 transmits cleanly as 0,1,1,0.
- Ignored load: pulse `load_valid` with 4'b0000 mid-frame -> the current frame is unaltered and no extra frame is sent.
- Parity build: `din`=4'b1011 -> `sout` = 1,1,0,1,1, with `last` only on the 5th bit. `din`=4'b1001 -> parity bit 0.
